// File: rtl/barcode_rdr_if.sv
// Barcode reader bus: raw sensor line and consumer acknowledge in, decoded ID and sticky valid out.
// Latency: none, wires only.
// Backpressure: none; the consumer acknowledges via clr_ID_vld and ID_vld stays set until then.
// Ports: BC (sensor, idle high), clr_ID_vld (ack), ID[7:0], ID_vld.
interface barcode_rdr_if;
  logic       BC;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;

  // Reader side
  modport slave (
    input  BC,
    input  clr_ID_vld,
    output ID,
    output ID_vld
  );

  // Sensor / consumer side
  modport master (
    output BC,
    output clr_ID_vld,
    input  ID,
    input  ID_vld
  );
endinterface

// File: rtl/barcode_rdr.sv
// Pulse-width barcode decoder: measures the start pulse, then decodes 8 bits MSB first into a station ID.
// Latency: ID/ID_vld update 1 cycle after the 8th sample point (BC goes through 2 sync flops first).
// Backpressure: none; ID_vld is sticky until clr_ID_vld, and a new valid frame overwrites ID.
// Ports: clk, rst_n (async active-low), bus (barcode_rdr_if.slave: BC, clr_ID_vld, ID, ID_vld).
module barcode_rdr #(
  parameter int          DUR_W   = 22,
  parameter int unsigned TIMEOUT = 32'h003F_FFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  barcode_rdr_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    START_LO,
    WAIT_FALL,
    SAMPLE_WAIT
  } state_t;

  localparam logic [DUR_W-1:0] L_SAT = {DUR_W{1'b1}};
  localparam logic [DUR_W-1:0] L_ONE = {{(DUR_W-1){1'b0}}, 1'b1};
  localparam logic [DUR_W-1:0] L_TMO = DUR_W'(TIMEOUT);

  // BC is asynchronous: two flops to synchronise, a third for edge detection
  logic             r_bc_meta;
  logic             r_bc_s;
  logic             r_bc_p;
  logic             w_fall;
  logic             w_rise;

  state_t           r_state;
  logic [DUR_W-1:0] r_dur_cnt;
  logic [DUR_W-1:0] r_start_dur;
  logic [DUR_W-1:0] r_tmo_cnt;
  logic [DUR_W-1:0] r_smp_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_done;
  logic [7:0]       r_id;
  logic             r_id_vld;

  assign w_fall = r_bc_p & ~r_bc_s;
  assign w_rise = ~r_bc_p & r_bc_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bc_meta <= 1'b1;
      r_bc_s    <= 1'b1;
      r_bc_p    <= 1'b1;
    end else begin
      r_bc_meta <= bus.BC;
      r_bc_s    <= r_bc_meta;
      r_bc_p    <= r_bc_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dur_cnt   <= '0;
      r_start_dur <= '0;
      r_tmo_cnt   <= '0;
      r_smp_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_done      <= 1'b0;
      r_id        <= '0;
      r_id_vld    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_dur_cnt <= L_ONE;
            r_state   <= START_LO;
          end
        end

        START_LO: begin
          if (w_rise) begin
            r_start_dur <= r_dur_cnt;
            r_bit_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_state     <= WAIT_FALL;
          end else if (r_dur_cnt == L_SAT) begin
            // line stuck low: not a barcode
            r_state <= IDLE;
          end else if (!r_bc_s) begin
            r_dur_cnt <= r_dur_cnt + L_ONE;
          end
        end

        WAIT_FALL: begin
          if (w_fall) begin
            r_smp_cnt <= L_ONE;
            r_state   <= SAMPLE_WAIT;
          end else if (r_tmo_cnt == L_TMO) begin
            // frame abandoned mid-way; ID/ID_vld keep the last good value
            r_state <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + L_ONE;
          end
        end

        SAMPLE_WAIT: begin
          // Sample one start-pulse width after the bit's falling edge:
          // a short pulse has already returned high (1), a long one is still low (0).
          // Edges before the sample point are ignored.
          if (r_smp_cnt == r_start_dur) begin
            r_shift   <= {r_shift[6:0], r_bc_s};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_tmo_cnt <= '0;
              r_state   <= WAIT_FALL;
            end
          end else begin
            r_smp_cnt <= r_smp_cnt + L_ONE;
          end
        end

        default: r_state <= IDLE;
      endcase

      // Only whole frames with a 2'b00 prefix reach the port; a new valid
      // frame takes priority over a simultaneous acknowledge.
      if (r_done && (r_shift[7:6] == 2'b00)) begin
        r_id     <= r_shift;
        r_id_vld <= 1'b1;
      end else if (bus.clr_ID_vld) begin
        r_id_vld <= 1'b0;
      end
    end
  end

  assign bus.ID     = r_id;
  assign bus.ID_vld = r_id_vld;

endmodule

// File: tb/tb_barcode_rdr.sv
// Self-checking bench for barcode_rdr: table of frames, hand-timed corner sequences, random frames vs. a frame-level model.
// Latency: checks the exact 1-cycle completion latency after the 8th sample point.
// Backpressure: exercises the clr_ID_vld acknowledge, including acknowledge coinciding with a new frame.
module tb_barcode_rdr;

  logic clk;
  logic rst_n;
  logic bc  [3];
  logic clr [3];
  int   sel;
  int   n_cmp;
  int   n_err;

  // Frame-level model state for the randomized section
  logic [7:0] m_id;
  logic       m_vld;

  barcode_rdr_if if_a ();
  barcode_rdr_if if_b ();
  barcode_rdr_if if_c ();

  assign if_a.BC = bc[0];
  assign if_b.BC = bc[1];
  assign if_c.BC = bc[2];
  assign if_a.clr_ID_vld = clr[0];
  assign if_b.clr_ID_vld = clr[1];
  assign if_c.clr_ID_vld = clr[2];

  // A: short timeout for the abort test; B: full-width defaults for slow timing; C: narrow counters for saturation
  barcode_rdr #(.DUR_W(22), .TIMEOUT(500))          u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  barcode_rdr #(.DUR_W(22), .TIMEOUT(32'h003F_FFFF)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  barcode_rdr #(.DUR_W(8),  .TIMEOUT(200))          u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] dat;
    int         ls;
    int         lo1;
    int         lo0;
    int         per;
    bit         clr_after;
    logic [7:0] exp_id;
    logic       exp_vld;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [7:0] get_id();
    case (sel)
      0:       return if_a.ID;
      1:       return if_b.ID;
      default: return if_c.ID;
    endcase
  endfunction

  function automatic logic get_vld();
    case (sel)
      0:       return if_a.ID_vld;
      1:       return if_b.ID_vld;
      default: return if_c.ID_vld;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr[sel] = 1'b1;
    cyc(1);
    clr[sel] = 1'b0;
  endtask

  // Start pulse of ls cycles low, then nbits bits MSB first
  task automatic send_bits(logic [7:0] d, int ls, int lo1, int lo0, int per, int nbits);
    int lo;
    bc[sel] = 1'b0;
    cyc(ls);
    bc[sel] = 1'b1;
    cyc(per / 2);
    for (int i = 0; i < nbits; i++) begin
      lo = d[7-i] ? lo1 : lo0;
      bc[sel] = 1'b0;
      cyc(lo);
      bc[sel] = 1'b1;
      cyc(per - lo);
    end
  endtask

  // Final bit with cycle-exact checks. The 8th sample lands sd+3 negedges
  // after the fall is driven (2 sync flops + edge detect); ID_vld rises one cycle later.
  task automatic last_bit(int lo, int sd, bit align, logic [7:0] exp_id);
    bc[sel] = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == lo) bc[sel] = 1'b1;
      if (k == sd + 3) begin
        chk("lat_pre_vld", 32'(get_vld()), 32'd0);
        if (align) clr[sel] = 1'b1;
      end
      if (k == sd + 4) begin
        if (align) clr[sel] = 1'b0;
        chk(align ? "set_wins_vld" : "lat_vld", 32'(get_vld()), 32'd1);
        chk(align ? "set_wins_id" : "lat_id", 32'(get_id()), 32'(exp_id));
      end
      if (align && k == sd + 5) chk("set_wins_hold", 32'(get_vld()), 32'd1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sel   = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bc[i]  = 1'b1;
      clr[i] = 1'b0;
    end

    tbl[0] = '{8'hC5, 40, 20, 60, 100, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'h15, 40, 20, 60, 100, 1'b0, 8'h15, 1'b1};
    tbl[2] = '{8'h3C, 30, 10, 45,  90, 1'b0, 8'h3C, 1'b1};
    tbl[3] = '{8'hFF, 50, 25, 70, 120, 1'b0, 8'h3C, 1'b1};
    tbl[4] = '{8'h81, 40, 20, 60, 100, 1'b1, 8'h3C, 1'b1};
    tbl[5] = '{8'h00, 40, 20, 60, 100, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'h3F, 35, 15, 55, 100, 1'b1, 8'h3F, 1'b1};

    cyc(3);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      chk("rst_id", 32'(get_id()), 32'd0);
      chk("rst_vld", 32'(get_vld()), 32'd0);
    end
    rst_n = 1'b1;
    sel   = 0;
    cyc(5);

    // Table-driven frames on A
    for (int i = 0; i < 7; i++) begin
      send_bits(tbl[i].dat, tbl[i].ls, tbl[i].lo1, tbl[i].lo0, tbl[i].per, 8);
      cyc(10);
      chk($sformatf("tbl%0d_id", i), 32'(get_id()), 32'(tbl[i].exp_id));
      chk($sformatf("tbl%0d_vld", i), 32'(get_vld()), 32'(tbl[i].exp_vld));
      if (tbl[i].clr_after) begin
        pulse_clr();
        cyc(2);
      end
    end

    // Exact completion latency for 0x2A, then sticky for 500 idle cycles
    send_bits(8'h2A, 40, 20, 60, 100, 7);
    last_bit(60, 40, 1'b0, 8'h2A);
    cyc(500);
    chk("vld_sticky", 32'(get_vld()), 32'd1);

    // One-cycle acknowledge
    clr[0] = 1'b1;
    cyc(1);
    clr[0] = 1'b0;
    chk("clr_vld", 32'(get_vld()), 32'd0);
    chk("clr_id_kept", 32'(get_id()), 32'h2A);
    cyc(20);

    // Acknowledge coinciding with completion of 0x3F
    send_bits(8'h3F, 40, 20, 60, 100, 7);
    last_bit(20, 40, 1'b1, 8'h3F);
    pulse_clr();
    cyc(5);

    // Mid-frame timeout, then recovery
    send_bits(8'h07, 40, 20, 60, 100, 3);
    cyc(600);
    chk("tmo_vld", 32'(get_vld()), 32'd0);
    chk("tmo_id", 32'(get_id()), 32'h3F);
    send_bits(8'h07, 40, 20, 60, 100, 8);
    cyc(10);
    chk("tmo_recover_id", 32'(get_id()), 32'h07);
    chk("tmo_recover_vld", 32'(get_vld()), 32'd1);

    // Reset during bit 4 of 0x2A
    send_bits(8'h2A, 40, 20, 60, 100, 3);
    bc[0] = 1'b0;
    cyc(10);
    rst_n = 1'b0;
    #1;
    chk("midrst_id", 32'(get_id()), 32'd0);
    chk("midrst_vld", 32'(get_vld()), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    bc[0] = 1'b1;
    cyc(20);
    send_bits(8'h11, 40, 20, 60, 100, 8);
    cyc(10);
    chk("postrst_id", 32'(get_id()), 32'h11);
    chk("postrst_vld", 32'(get_vld()), 32'd1);

    // Random frames against the frame-level model
    m_id  = 8'h11;
    m_vld = 1'b1;
    for (int f = 0; f < 25; f++) begin
      logic [7:0] d;
      int ls, lo1, lo0, per;
      d = 8'($urandom);
      if ($urandom_range(1, 0) == 1) d[7:6] = 2'b00;
      ls  = int'($urandom_range(60, 30));
      lo1 = int'($urandom_range(ls - 5, 5));
      lo0 = int'($urandom_range(ls + 40, ls + 5));
      per = lo0 + int'($urandom_range(40, 5));
      send_bits(d, ls, lo1, lo0, per, 8);
      cyc(10);
      if (d[7:6] == 2'b00) begin
        m_id  = d;
        m_vld = 1'b1;
      end
      chk($sformatf("rnd%0d_id(d=%0h)", f, d), 32'(get_id()), 32'(m_id));
      chk($sformatf("rnd%0d_vld(d=%0h)", f, d), 32'(get_vld()), 32'(m_vld));
      if ($urandom_range(3, 0) == 0) begin
        pulse_clr();
        m_vld = 1'b0;
        cyc(2);
      end
    end

    // Ten-times-slower timing on B
    sel = 1;
    send_bits(8'h3C, 400, 200, 600, 1000, 8);
    cyc(10);
    chk("slow_id", 32'(get_id()), 32'h3C);
    chk("slow_vld", 32'(get_vld()), 32'd1);

    // Line held low past saturation on C (DUR_W=8), then a normal frame
    sel = 2;
    bc[2] = 1'b0;
    cyc(300);
    bc[2] = 1'b1;
    cyc(100);
    chk("sat_vld", 32'(get_vld()), 32'd0);
    chk("sat_id", 32'(get_id()), 32'd0);
    send_bits(8'h2A, 40, 20, 60, 100, 8);
    cyc(10);
    chk("sat_recover_id", 32'(get_id()), 32'h2A);
    chk("sat_recover_vld", 32'(get_vld()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/barcode_rdr.md
Name: barcode_rdr

Overview:
Serial barcode decoder that produces the station ID consumed by the follower's command controller.
- Watches the IR barcode sensor line BC (idle high).
- Measures the width of the start pulse, then decodes 8 pulse-width-encoded bits, MSB first.
- Presents a validated 8-bit ID with a sticky ID_vld flag, cleared via clr_ID_vld from the consumer.

Parameters:
DUR_W, 22, width of the duration and timeout counters; saturation value 2^DUR_W-1.
TIMEOUT, 22'h3FFFFF, maximum cycles allowed in WAIT_FALL mid-frame before the frame is aborted.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
BC  input  1  raw barcode sensor line; asynchronous to clk; idle high
clr_ID_vld  input  1  consumer acknowledge; clears ID_vld
ID  output  8  last valid decoded ID
ID_vld  output  1  sticky valid flag for ID

Behaviour:
- Reset rst_n is asynchronous and active-low; clock is clk. Reset drives ID=8'h00, ID_vld=0, state=IDLE and clears all counters and the shift register. Sync flops reset to 1 (idle).
- Synchronisation:
  - BC passes through two flops (bc_s), then one more (bc_p).
  - fall = bc_p & ~bc_s; rise = ~bc_p & bc_s.
  - All decoding uses bc_s only.
- States: IDLE, START_LO, WAIT_FALL, SAMPLE_WAIT.
- IDLE: on fall, dur_cnt<=1, go to START_LO. Otherwise hold.
- START_LO:
  - While bc_s=0, dur_cnt increments by 1.
  - On rise: start_dur<=dur_cnt, bit_cnt<=0, tmo_cnt<=0, go to WAIT_FALL.
  - If dur_cnt reaches 2^DUR_W-1 with no rise: abort to IDLE.
- WAIT_FALL:
  - tmo_cnt increments each cycle.
  - On fall: smp_cnt<=1, go to SAMPLE_WAIT.
  - If tmo_cnt==TIMEOUT: abort to IDLE. ID and ID_vld are untouched.
- SAMPLE_WAIT:
  - smp_cnt increments each cycle.
  - In the cycle smp_cnt==start_dur: shift <= {shift[6:0], bc_s} and bit_cnt++.
  - If bit_cnt was 7 (8th bit): frame complete, go to IDLE. Otherwise tmo_cnt<=0 and go to WAIT_FALL.
  - Bit encoding: a low pulse shorter than start_dur decodes as 1; a low pulse longer than start_dur decodes as 0. Pulse width equal to start_dur is undefined (bench must not use it).
- Frame completion, in the cycle after the 8th sample:
  - If shift[7:6]==2'b00: ID<=shift, ID_vld<=1.
  - Otherwise: frame discarded; ID and ID_vld unchanged.
- ID_vld handshake:
  - ID_vld stays set until clr_ID_vld=1, then clears the next cycle.
  - Valid frame completing in the same cycle as clr_ID_vld: set wins (ID_vld=1, new ID).
  - Valid frame while ID_vld=1: ID is overwritten and ID_vld stays 1.
- Fall edges are ignored in SAMPLE_WAIT until the sample point has been taken.
- No partial ID is ever visible on the ID port.
- Reset asserted mid-frame: immediate return to the reset state; no ID_vld.

Test Plan:
1. Valid frame: start low 40 cycles; 8 bits at 100-cycle period, '1' = 20 low / 80 high, '0' = 60 low / 40 high; send 0x2A -> ID=8'h2A, ID_vld=1 exactly 1 cycle after the 8th sample point; ID_vld stays 1 for 500 idle cycles.
2. Invalid prefix: send 0xC5 with the same timing -> ID_vld stays 0 and ID keeps its prior value (8'h00 after reset); send 0x15 next -> ID=8'h15, ID_vld=1.
3. Handshake: after test 1, pulse clr_ID_vld for 1 cycle -> ID_vld=0 the next cycle and ID still 8'h2A. Then align clr_ID_vld with the completion cycle of a 0x3F frame -> ID_vld=1, ID=8'h3F.
4. Timeout: with TIMEOUT=500, send start plus 3 bits, then hold BC high -> after 500 cycles state returns to IDLE with no ID_vld. A subsequent full 0x07 frame decodes correctly (ID=8'h07).
5. Reset mid-frame: assert rst_n=0 during bit 4 of a 0x2A frame -> ID=0, ID_vld=0 immediately; after release, a fresh 0x11 frame gives ID=8'h11, ID_vld=1.
6. Timing scaling: start low 400 cycles with a 1000-cycle bit period ('1' = 200 low, '0' = 600 low); send 0x3C -> ID=8'h3C. Also hold BC low beyond saturation with DUR_W=8 -> abort to IDLE, no ID_vld.
